sincos_nco_mc: RTL

- Multi-channel, time-multiplexed numerically controlled oscillator.
- Each channel has a 32-bit phase accumulator, a programmable frequency word and a sine/cosine select.
- Phase is folded to a quarter-wave, looked up in an external coarse/slope ROM, linearly interpolated and sign-restored.
- Successor to the single-channel interpolating cosine stage; feeds the DDS/mixer datapath with one sample per enabled clock, tagged by channel.

---
 rtl/sincos_nco_mc.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sincos_nco_mc.sv
// Time-multiplexed multi-channel sin/cos NCO: per-channel phase accumulators,
// quarter-wave fold, external coarse/slope ROM and linear interpolation.

module sincos_nco_mc_ch (
  input  logic        c,
  input  logic        rn,
  input  logic        inc,
  input  logic        wr_f,
  input  logic        wr_p,
  input  logic [31:0] wd,
  input  logic        ws,
  output logic [25:0] phase_hi,
  output logic        sel
);
  logic [31:0] phase_q, phase_d, freq_q, freq_d;
  logic        sel_q, sel_d;

  // A phase write in the same cycle as this channel's increment wins.
  always_comb begin
    phase_d = phase_q;
    freq_d  = freq_q;
    sel_d   = sel_q;
    if (wr_p)     phase_d = wd;
    else if (inc) phase_d = phase_q + freq_q;
    if (wr_f) begin
      freq_d = wd;
      sel_d  = ws;
    end
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      phase_q <= '0;
      freq_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      freq_q  <= freq_d;
      sel_q   <= sel_d;
    end
  end

  assign phase_hi = phase_q[31:6];
  assign sel      = sel_q;
endmodule

module sincos_nco_mc #(
  parameter int NCH     = 4,
  parameter int NBO     = 23,
  parameter int ROM_LAT = 2,
  parameter int CW      = $clog2(NCH)
) (
  input  logic                  c,
  input  logic                  rn,
  input  logic                  en,
  input  logic                  we,
  input  logic                  wsel,
  input  logic [CW-1:0]         wa,
  input  logic [31:0]           wd,
  input  logic                  ws,
  output logic [9:0]            rom_a,
  input  logic [34:0]           rom_d,
  output logic signed [NBO-1:0] o,
  output logic [CW-1:0]         och,
  output logic                  ov
);
  localparam int DL     = ROM_LAT + 1;  // stage where rom_d lines up with its address
  localparam int STAGES = DL + 2;

  typedef struct packed {
    logic [13:0]   f;
    logic          neg;
    logic [CW-1:0] ch;
  } meta_t;

  logic [NCH-1:0][25:0] phase_hi;
  logic [NCH-1:0]       sel;

  logic [CW-1:0]        k_q, k_d;
  logic [9:0]           rom_a_q, rom_a_d;
  logic [STAGES:1]      vld_pipe_q, vld_pipe_d;
  meta_t [DL:1]         meta_q, meta_d;
  logic [21:0]          cf_q, cf_d;
  logic [26:0]          prod_q, prod_d;
  logic                 neg_m_q, neg_m_d;
  logic [CW-1:0]        ch_m_q, ch_m_d;
  logic signed [NBO-1:0] o_q, o_d;
  logic [CW-1:0]        och_q, och_d;

  logic [25:0]          p_hi, pf;
  logic                 sel_k, mir;
  logic [9:0]           idx;
  meta_t                fold_m;
  logic [35:0]          m;
  logic [36:0]          mx, v;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    sincos_nco_mc_ch u_ch (
      .c        (c),
      .rn       (rn),
      .inc      (en && (k_q == CW'(i))),
      .wr_f     (we && !wsel && (wa == CW'(i))),
      .wr_p     (we && wsel && (wa == CW'(i))),
      .wd       (wd),
      .ws       (ws),
      .phase_hi (phase_hi[i]),
      .sel      (sel[i])
    );
  end

  always_comb begin
    p_hi  = '0;
    sel_k = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (k_q == CW'(i)) begin
        p_hi  = phase_hi[i];
        sel_k = sel[i];
      end
    // Sine is cosine delayed by a quarter turn (2^30 >> 6 in the upper field).
    pf          = sel_k ? p_hi - 26'h100_0000 : p_hi;
    mir         = pf[24];
    idx         = mir ? ~pf[23:14] : pf[23:14];
    fold_m.f    = mir ? ~pf[13:0] : pf[13:0];
    fold_m.neg  = pf[25] ^ pf[24];
    fold_m.ch   = k_q;

    k_d     = k_q;
    rom_a_d = rom_a_q;
    if (en) begin
      k_d     = (k_q == CW'(NCH - 1)) ? '0 : k_q + CW'(1);
      rom_a_d = idx;
    end
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], en};
    meta_d     = {meta_q[DL-1:1], fold_m};

    cf_d    = cf_q;
    prod_d  = prod_q;
    neg_m_d = neg_m_q;
    ch_m_d  = ch_m_q;
    if (vld_pipe_q[DL]) begin
      cf_d    = rom_d[34:13];
      prod_d  = 27'(rom_d[12:0]) * 27'(meta_q[DL].f);
      neg_m_d = meta_q[DL].neg;
      ch_m_d  = meta_q[DL].ch;
    end

    m  = {cf_q, 14'b0} - 36'(prod_q);
    mx = {1'b0, m};
    v  = neg_m_q ? ~mx + 37'd1 : mx;

    o_d   = o_q;
    och_d = och_q;
    if (vld_pipe_q[DL+1]) begin
      o_d   = NBO'($signed(v) >>> (37 - NBO));
      och_d = ch_m_q;
    end
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      k_q        <= '0;
      rom_a_q    <= '0;
      vld_pipe_q <= '0;
      meta_q     <= '0;
      cf_q       <= '0;
      prod_q     <= '0;
      neg_m_q    <= 1'b0;
      ch_m_q     <= '0;
      o_q        <= '0;
      och_q      <= '0;
    end else begin
      k_q        <= k_d;
      rom_a_q    <= rom_a_d;
      vld_pipe_q <= vld_pipe_d;
      meta_q     <= meta_d;
      cf_q       <= cf_d;
      prod_q     <= prod_d;
      neg_m_q    <= neg_m_d;
      ch_m_q     <= ch_m_d;
      o_q        <= o_d;
      och_q      <= och_d;
    end
  end

  assign rom_a = rom_a_q;
  assign o     = o_q;
  assign och   = och_q;
  assign ov    = vld_pipe_q[STAGES];
endmodule
